// File: rtl/data_mem_bank.sv
// data_mem_bank
//   Data-memory controller between the load/store unit and a word-wide block
//   RAM. Adds a base-address window, an LED MMIO register and range/alignment
//   error reporting. Handles byte/half/word access with sign/zero-extended
//   loads and read-merge-write stores. Every access takes the same three-edge
//   sequence (latch, fetch, complete) and stalls the requester throughout.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting; latches addr/data/mask/op when a request is seen
//   FETCH | reads the addressed RAM word into word_buf
//   READ  | drives read_data (extracted RAM value, LED value or 0)
//   WRITE | writes the merged word to RAM or updates the LED register
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   addr         byte address (sampled in IDLE)
//   write_data   store data, sub-word data right-aligned (sampled in IDLE)
//   memwrite     store request
//   memread      load request; takes priority over memwrite
//   sign_mask    [3] sign-extend, [2:0] 001 byte / 011 half / 111 word
//   read_data    registered load result
//   led          LED register
//   clk_stall    high while an access is in flight
//   err          one-cycle pulse on an out-of-range/misaligned/bad-size access

module data_mem_bank #(
  parameter int unsigned    DEPTH     = 1024,
  parameter logic [31:0]    BASE_ADDR = 32'h0000_4000,
  parameter logic [31:0]    LED_ADDR  = 32'h0000_2000,
  parameter int unsigned    LED_WIDTH = 8,
  parameter string          INIT_FILE = "verilog/data.hex"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr,
  input  logic [31:0]          write_data,
  input  logic                 memwrite,
  input  logic                 memread,
  input  logic [3:0]           sign_mask,
  output logic [31:0]          read_data,
  output logic [LED_WIDTH-1:0] led,
  output logic                 clk_stall,
  output logic                 err
);

  localparam int unsigned AW      = $clog2(DEPTH);
  // 33-bit end address so a window touching the top of the address space
  // cannot wrap around to zero.
  localparam logic [32:0] RAM_END = {1'b0, BASE_ADDR} + (33'(DEPTH) << 2);

  typedef enum logic [1:0] {IDLE, FETCH, READ, WRITE} state_t;

  state_t         state, state_nx;
  logic [31:0]    addr_l, wdata_l;
  logic [3:0]     mask_l;
  logic           op_rd;
  logic [31:0]    word_buf;
  logic [31:0]    ram [DEPTH];

  logic [AW-1:0]  idx;
  logic           in_ram, is_led, is_byte, is_half, is_word, size_ok;
  logic           misaligned, bad, ram_we;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic [31:0]    rd_val, merged;

  // ---------------- decode on latched values ----------------
  assign idx     = AW'((addr_l - BASE_ADDR) >> 2);
  assign in_ram  = (addr_l >= BASE_ADDR) && ({1'b0, addr_l} < RAM_END);
  assign is_led  = (addr_l == LED_ADDR);
  assign is_byte = (mask_l[2:0] == 3'b001);
  assign is_half = (mask_l[2:0] == 3'b011);
  assign is_word = (mask_l[2:0] == 3'b111);
  assign size_ok = is_byte | is_half | is_word;

  assign misaligned = (is_half && addr_l[0]) || (is_word && (addr_l[1:0] != 2'b00));
  // The LED register only accepts whole-word access.
  assign bad = (!in_ram && !is_led) || misaligned || !size_ok || (is_led && !is_word);

  // ---------------- load extraction ----------------
  assign byte_sel = word_buf[{addr_l[1:0], 3'b000} +: 8];
  assign half_sel = word_buf[{addr_l[1], 4'b0000} +: 16];

  always_comb begin
    rd_val = 32'h0;
    if (bad) begin
      rd_val = 32'h0;
    end else if (is_led) begin
      rd_val = 32'(led);
    end else if (is_byte) begin
      rd_val = {{24{mask_l[3] & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      rd_val = {{16{mask_l[3] & half_sel[15]}}, half_sel};
    end else begin
      rd_val = word_buf;
    end
  end

  // ---------------- store merge ----------------
  always_comb begin
    merged = word_buf;
    if (is_byte) begin
      merged[{addr_l[1:0], 3'b000} +: 8] = wdata_l[7:0];
    end else if (is_half) begin
      merged[{addr_l[1], 4'b0000} +: 16] = wdata_l[15:0];
    end else if (is_word) begin
      merged = wdata_l;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_nx = state;
    ram_we   = 1'b0;
    case (state)
      IDLE:    if (memread || memwrite) state_nx = FETCH;
      FETCH:   state_nx = op_rd ? READ : WRITE;
      READ:    state_nx = IDLE;
      WRITE: begin
        state_nx = IDLE;
        ram_we   = !bad && in_ram;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clk_stall <= 1'b0;
      read_data <= 32'h0;
      led       <= '0;
      err       <= 1'b0;
      addr_l    <= 32'h0;
      wdata_l   <= 32'h0;
      mask_l    <= 4'h0;
      op_rd     <= 1'b0;
    end else begin
      state <= state_nx;
      err   <= 1'b0;
      case (state)
        IDLE: begin
          if (memread || memwrite) begin
            addr_l    <= addr;
            wdata_l   <= write_data;
            mask_l    <= sign_mask;
            op_rd     <= memread;
            clk_stall <= 1'b1;
          end else begin
            clk_stall <= 1'b0;
          end
        end
        READ: begin
          read_data <= rd_val;
          err       <= bad;
          clk_stall <= 1'b0;
        end
        WRITE: begin
          if (!bad && is_led) led <= wdata_l[LED_WIDTH-1:0];
          err       <= bad;
          clk_stall <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // RAM port kept free of reset so it maps onto block RAM. An abort by reset
  // forces state back to IDLE, so ram_we cannot fire afterwards.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= merged;
    if (state == FETCH) word_buf <= ram[idx];
  end

endmodule
